// File: rtl/bus_arbiter_2m1s_pkg.sv
// Shared transfer types and the latched request payload for the 2-master/1-slave arbiter.
package bus_arbiter_2m1s_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

  typedef struct packed {
    ttype_e              ttype;
    tsize_e              tsize;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } req_t;

endpackage

// File: rtl/bus_arbiter_2m1s_if.sv
// Simple request/complete bus; master drives the request, slave returns completion.
interface bus_arbiter_2m1s_if;
  import bus_arbiter_2m1s_pkg::*;

  logic              bstart;
  ttype_e            ttype;
  tsize_e            tsize;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              bdone;
  logic              berr;

  modport master (output bstart, ttype, tsize, addr, wdata,
                  input  rdata, bdone, berr);
  modport slave  (input  bstart, ttype, tsize, addr, wdata,
                  output rdata, bdone, berr);
endinterface

// File: rtl/bus_arbiter_2m1s.sv
// Merges dbus (m0) and ibus (m1) onto one slave port; latches the granted request,
// routes completion back to its owner and forces an error completion on timeout.
module bus_arbiter_2m1s
  import bus_arbiter_2m1s_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic               clk,
  input  logic               rst,
  bus_arbiter_2m1s_if.slave  m0,
  bus_arbiter_2m1s_if.slave  m1,
  bus_arbiter_2m1s_if.master s
);

  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e           state;
  state_e           state_nxt;
  logic             last_grant;
  logic             aborted;
  logic [CNT_W-1:0] cnt;
  logic             s_bstart_q;
  req_t             req_q;
  req_t             req_sel;
  logic             owner_req;
  logic             timeout_c;
  logic             finish_c;
  logic             deliver_c;

  assign owner_req = (state == GRANT1) ? m1.bstart : m0.bstart;
  assign timeout_c = (state != IDLE) && !s.bdone && (cnt == CNT_LAST);
  assign finish_c  = (state != IDLE) && (s.bdone || timeout_c);
  // An owner that dropped bstart at any point during its grant gets no completion.
  assign deliver_c = finish_c && owner_req && !aborted && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: arbitrate only from IDLE, so every grant is followed by an IDLE cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0.bstart && m1.bstart)
          state_nxt = (ROUND_ROBIN && !last_grant) ? GRANT1 : GRANT0;
        else if (m0.bstart)
          state_nxt = GRANT0;
        else if (m1.bstart)
          state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (finish_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_sel = '{ttype: m0.ttype, tsize: m0.tsize, addr: m0.addr, wdata: m0.wdata};
    if (state_nxt == GRANT1)
      req_sel = '{ttype: m1.ttype, tsize: m1.tsize, addr: m1.addr, wdata: m1.wdata};
  end

  // Slave request registers, grant history, timeout counter and abort flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s_bstart_q <= 1'b0;
      req_q      <= '{ttype: READ, tsize: WORD, addr: '0, wdata: '0};
      last_grant <= 1'b1;
      cnt        <= '0;
      aborted    <= 1'b0;
    end else if (state == IDLE) begin
      if (state_nxt != IDLE) begin
        s_bstart_q <= 1'b1;
        req_q      <= req_sel;
        last_grant <= (state_nxt == GRANT1);
        cnt        <= '0;
        aborted    <= 1'b0;
      end
    end else if (finish_c) begin
      s_bstart_q <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (!owner_req) aborted <= 1'b1;
    end
  end

  assign s.bstart = s_bstart_q;
  assign s.ttype  = req_q.ttype;
  assign s.tsize  = req_q.tsize;
  assign s.addr   = req_q.addr;
  assign s.wdata  = req_q.wdata;

  // Completion routing: combinational from s_bdone or the timeout
  always_comb begin
    m0.bdone = 1'b0;
    m0.berr  = 1'b0;
    m0.rdata = '0;
    m1.bdone = 1'b0;
    m1.berr  = 1'b0;
    m1.rdata = '0;
    if (deliver_c) begin
      if (state == GRANT0) begin
        m0.bdone = 1'b1;
        m0.berr  = timeout_c;
        m0.rdata = timeout_c ? '0 : s.rdata;
      end else begin
        m1.bdone = 1'b1;
        m1.berr  = timeout_c;
        m1.rdata = timeout_c ? '0 : s.rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m1s.sv
// Bench for bus_arbiter_2m1s: directed vector table, corner sequences and a random run
// checked against a transaction-level model, on a round-robin and a fixed-priority instance.
module tb_bus_arbiter_2m1s;
  import bus_arbiter_2m1s_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_bs [2];
  ttype_e      m_tt [2];
  tsize_e      m_ts [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic        s_bdone;
  logic [31:0] s_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter_2m1s_if a_m0 ();
  bus_arbiter_2m1s_if a_m1 ();
  bus_arbiter_2m1s_if a_s ();
  bus_arbiter_2m1s_if b_m0 ();
  bus_arbiter_2m1s_if b_m1 ();
  bus_arbiter_2m1s_if b_s ();

  assign a_m0.bstart = m_bs[0];    assign b_m0.bstart = m_bs[0];
  assign a_m0.ttype  = m_tt[0];    assign b_m0.ttype  = m_tt[0];
  assign a_m0.tsize  = m_ts[0];    assign b_m0.tsize  = m_ts[0];
  assign a_m0.addr   = m_addr[0];  assign b_m0.addr   = m_addr[0];
  assign a_m0.wdata  = m_wdata[0]; assign b_m0.wdata  = m_wdata[0];
  assign a_m1.bstart = m_bs[1];    assign b_m1.bstart = m_bs[1];
  assign a_m1.ttype  = m_tt[1];    assign b_m1.ttype  = m_tt[1];
  assign a_m1.tsize  = m_ts[1];    assign b_m1.tsize  = m_ts[1];
  assign a_m1.addr   = m_addr[1];  assign b_m1.addr   = m_addr[1];
  assign a_m1.wdata  = m_wdata[1]; assign b_m1.wdata  = m_wdata[1];
  assign a_s.rdata   = s_rdata;    assign b_s.rdata   = s_rdata;
  assign a_s.bdone   = s_bdone;    assign b_s.bdone   = s_bdone;
  assign a_s.berr    = 1'b0;       assign b_s.berr    = 1'b0;

  bus_arbiter_2m1s #(.ROUND_ROBIN(1'b1), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .rst(rst), .m0(a_m0), .m1(a_m1), .s(a_s));
  bus_arbiter_2m1s #(.ROUND_ROBIN(1'b0), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .rst(rst), .m0(b_m0), .m1(b_m1), .s(b_s));

  // Index 0 = round-robin instance, 1 = fixed-priority instance
  logic        o_sbs [2];
  logic [31:0] o_saddr [2];
  logic [31:0] o_swdata [2];
  ttype_e      o_stt [2];
  tsize_e      o_sts [2];
  logic        o_done [2][2];
  logic        o_err [2][2];
  logic [31:0] o_rd [2][2];

  assign o_sbs[0]    = a_s.bstart; assign o_sbs[1]    = b_s.bstart;
  assign o_saddr[0]  = a_s.addr;   assign o_saddr[1]  = b_s.addr;
  assign o_swdata[0] = a_s.wdata;  assign o_swdata[1] = b_s.wdata;
  assign o_stt[0]    = a_s.ttype;  assign o_stt[1]    = b_s.ttype;
  assign o_sts[0]    = a_s.tsize;  assign o_sts[1]    = b_s.tsize;
  assign o_done[0][0] = a_m0.bdone; assign o_done[0][1] = a_m1.bdone;
  assign o_done[1][0] = b_m0.bdone; assign o_done[1][1] = b_m1.bdone;
  assign o_err[0][0]  = a_m0.berr;  assign o_err[0][1]  = a_m1.berr;
  assign o_err[1][0]  = b_m0.berr;  assign o_err[1][1]  = b_m1.berr;
  assign o_rd[0][0]   = a_m0.rdata; assign o_rd[0][1]   = a_m1.rdata;
  assign o_rd[1][0]   = b_m0.rdata; assign o_rd[1][1]   = b_m1.rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the slave, how long, and what was latched
  typedef struct {
    int   owner;
    int   elapsed;
    int   last;
    bit   aborted;
    req_t lat;
  } mdl_t;
  mdl_t mdl [2];

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.owner   = -1;
    m.elapsed = 0;
    m.last    = 1;
    m.aborted = 1'b0;
    m.lat     = '{ttype: READ, tsize: WORD, addr: '0, wdata: '0};
    return m;
  endfunction

  task automatic model_cycle(input int k, input bit rr);
    mdl_t m;
    bit busy, ok, err, dlv;
    int pick;
    logic e_done, e_err;
    logic [31:0] e_rd;
    m    = mdl[k];
    busy = (m.owner >= 0);
    ok   = busy && s_bdone;
    err  = busy && !s_bdone && (m.elapsed == int'(TMO));
    dlv  = 1'b0;
    if (busy) dlv = !rst && !m.aborted && m_bs[m.owner];
    chk($sformatf("dut%0d s_bstart", k), 32'(o_sbs[k]), 32'(busy));
    chk($sformatf("dut%0d s_addr", k), o_saddr[k], m.lat.addr);
    chk($sformatf("dut%0d s_wdata", k), o_swdata[k], m.lat.wdata);
    chk($sformatf("dut%0d s_ttype", k), 32'(o_stt[k]), 32'(m.lat.ttype));
    chk($sformatf("dut%0d s_tsize", k), 32'(o_sts[k]), 32'(m.lat.tsize));
    for (int j = 0; j < 2; j++) begin
      e_done = busy && (j == m.owner) && dlv && (ok || err);
      e_err  = e_done && err;
      e_rd   = (e_done && ok) ? s_rdata : 32'h0;
      chk($sformatf("dut%0d m%0d_bdone", k, j), 32'(o_done[k][j]), 32'(e_done));
      chk($sformatf("dut%0d m%0d_berr", k, j), 32'(o_err[k][j]), 32'(e_err));
      chk($sformatf("dut%0d m%0d_rdata", k, j), o_rd[k][j], e_rd);
    end
    if (rst) begin
      m = mdl_reset();
    end else if (!busy) begin
      pick = -1;
      if (m_bs[0] && m_bs[1]) pick = rr ? (1 - m.last) : 0;
      else if (m_bs[0])       pick = 0;
      else if (m_bs[1])       pick = 1;
      if (pick >= 0) begin
        m.owner   = pick;
        m.last    = pick;
        m.elapsed = 1;
        m.aborted = 1'b0;
        m.lat     = '{ttype: m_tt[pick], tsize: m_ts[pick], addr: m_addr[pick], wdata: m_wdata[pick]};
      end
    end else if (ok || err) begin
      m.owner = -1;
    end else begin
      m.elapsed = m.elapsed + 1;
      if (!m_bs[m.owner]) m.aborted = 1'b1;
    end
    mdl[k] = m;
  endtask

  typedef struct {
    logic        b0, b1, sbd;
    logic [31:0] srd, a1;
    logic        e_sbs;
    logic [31:0] e_addr, e_wdata;
    logic        e_d0, e_d1, e_e0, e_e1;
    logic [31:0] e_r0, e_r1;
  } vec_t;
  vec_t vec [13];

  function automatic vec_t mk(input logic b0, b1, sbd, input logic [31:0] srd, a1,
                              input logic sbs, input logic [31:0] eaddr, ewdata,
                              input logic d0, d1, input logic [31:0] r0, r1);
    vec_t v;
    v = '{b0: b0, b1: b1, sbd: sbd, srd: srd, a1: a1, e_sbs: sbs, e_addr: eaddr,
          e_wdata: ewdata, e_d0: d0, e_d1: d1, e_e0: 1'b0, e_e1: 1'b0, e_r0: r0, e_r1: r1};
    return v;
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    m_bs[0] = 1'b0;
    m_bs[1] = 1'b0;
    s_bdone = 1'b0;
    s_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl[0] = mdl_reset();
    mdl[1] = mdl_reset();
  endtask

  task automatic drive(input logic b0, b1, sbd, input logic [31:0] srd);
    m_bs[0] = b0;
    m_bs[1] = b1;
    s_bdone = sbd;
    s_rdata = srd;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    localparam logic [31:0] W0 = 32'h1234_5678;
    localparam logic [31:0] W1 = 32'hAAAA_5555;
    vec[0]  = mk(0, 1, 0, 32'h0,         32'h100, 0, 32'h0,   32'h0, 0, 0, 32'h0,  32'h0);
    vec[1]  = mk(0, 1, 1, 32'hDEAD_BEEF, 32'h100, 1, 32'h100, W1,    0, 1, 32'h0,  32'hDEAD_BEEF);
    vec[2]  = mk(0, 0, 0, 32'h0,         32'h100, 0, 32'h100, W1,    0, 0, 32'h0,  32'h0);
    vec[3]  = mk(1, 1, 0, 32'h0,         32'h300, 0, 32'h100, W1,    0, 0, 32'h0,  32'h0);
    vec[4]  = mk(1, 1, 1, 32'h55,        32'h300, 1, 32'h200, W0,    1, 0, 32'h55, 32'h0);
    vec[5]  = mk(0, 1, 0, 32'h0,         32'h300, 0, 32'h200, W0,    0, 0, 32'h0,  32'h0);
    vec[6]  = mk(0, 1, 1, 32'h77,        32'h300, 1, 32'h300, W1,    0, 1, 32'h0,  32'h77);
    vec[7]  = mk(1, 1, 0, 32'h0,         32'h300, 0, 32'h300, W1,    0, 0, 32'h0,  32'h0);
    vec[8]  = mk(1, 1, 0, 32'h0,         32'h300, 1, 32'h200, W0,    0, 0, 32'h0,  32'h0);
    vec[9]  = mk(1, 1, 1, 32'h99,        32'h300, 1, 32'h200, W0,    1, 0, 32'h99, 32'h0);
    vec[10] = mk(0, 1, 0, 32'h0,         32'h300, 0, 32'h200, W0,    0, 0, 32'h0,  32'h0);
    vec[11] = mk(0, 1, 1, 32'h1,         32'h300, 1, 32'h300, W1,    0, 1, 32'h0,  32'h1);
    vec[12] = mk(0, 0, 0, 32'h0,         32'h300, 0, 32'h300, W1,    0, 0, 32'h0,  32'h0);

    m_tt[0] = WRITE; m_ts[0] = HALF; m_addr[0] = 32'h200; m_wdata[0] = W0;
    m_tt[1] = READ;  m_ts[1] = WORD; m_addr[1] = 32'h100; m_wdata[1] = W1;
    do_reset();

    // Reset state on both instances
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d s_bstart", k), 32'(o_sbs[k]), 32'h0);
      chk($sformatf("rst%0d s_addr", k), o_saddr[k], 32'h0);
      chk($sformatf("rst%0d s_wdata", k), o_swdata[k], 32'h0);
      chk($sformatf("rst%0d s_ttype", k), 32'(o_stt[k]), 32'(READ));
      chk($sformatf("rst%0d s_tsize", k), 32'(o_sts[k]), 32'(WORD));
      chk($sformatf("rst%0d bdone", k), 32'({o_done[k][1], o_done[k][0]}), 32'h0);
      chk($sformatf("rst%0d berr", k), 32'({o_err[k][1], o_err[k][0]}), 32'h0);
    end
    adv();

    // Vector table on the round-robin instance
    for (int i = 0; i < 13; i++) begin
      m_addr[1] = vec[i].a1;
      drive(vec[i].b0, vec[i].b1, vec[i].sbd, vec[i].srd);
      chk($sformatf("vec%0d s_bstart", i), 32'(o_sbs[0]), 32'(vec[i].e_sbs));
      chk($sformatf("vec%0d s_addr", i), o_saddr[0], vec[i].e_addr);
      chk($sformatf("vec%0d s_wdata", i), o_swdata[0], vec[i].e_wdata);
      chk($sformatf("vec%0d m0_bdone", i), 32'(o_done[0][0]), 32'(vec[i].e_d0));
      chk($sformatf("vec%0d m1_bdone", i), 32'(o_done[0][1]), 32'(vec[i].e_d1));
      chk($sformatf("vec%0d m0_berr", i), 32'(o_err[0][0]), 32'(vec[i].e_e0));
      chk($sformatf("vec%0d m1_berr", i), 32'(o_err[0][1]), 32'(vec[i].e_e1));
      chk($sformatf("vec%0d m0_rdata", i), o_rd[0][0], vec[i].e_r0);
      chk($sformatf("vec%0d m1_rdata", i), o_rd[0][1], vec[i].e_r1);
      adv();
    end

    // Both masters always requesting, instant slave: fixed priority starves m1, round-robin alternates
    do_reset();
    m_addr[0] = 32'h200;
    m_addr[1] = 32'h300;
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, 1, 32'h42);
      chk($sformatf("fp c%0d m0_bdone", c), 32'(o_done[1][0]), 32'(c % 2));
      chk($sformatf("fp c%0d m1_bdone", c), 32'(o_done[1][1]), 32'h0);
      if (c % 2 == 1) begin
        chk($sformatf("fp c%0d s_addr", c), o_saddr[1], 32'h200);
        chk($sformatf("rr c%0d s_addr", c), o_saddr[0], (c % 4 == 1) ? 32'h200 : 32'h300);
      end
      adv();
    end

    // Timeout with a silent slave, then a late s_bdone in IDLE
    do_reset();
    m_addr[0] = 32'h400;
    drive(1, 0, 0, 32'hFFFF_FFFF);
    chk("to idle s_bstart", 32'(o_sbs[0]), 32'h0);
    adv();
    for (int c = 1; c < 4; c++) begin
      drive(1, 0, 0, 32'hFFFF_FFFF);
      chk($sformatf("to c%0d s_bstart", c), 32'(o_sbs[0]), 32'h1);
      chk($sformatf("to c%0d m0_bdone", c), 32'(o_done[0][0]), 32'h0);
      adv();
    end
    drive(1, 0, 0, 32'hFFFF_FFFF);
    chk("to m0_bdone", 32'(o_done[0][0]), 32'h1);
    chk("to m0_berr", 32'(o_err[0][0]), 32'h1);
    chk("to m0_rdata", o_rd[0][0], 32'h0);
    adv();
    drive(0, 0, 1, 32'h1111_1111);
    chk("late s_bstart", 32'(o_sbs[0]), 32'h0);
    chk("late bdone", 32'({o_done[0][1], o_done[0][0]}), 32'h0);
    adv();

    // s_bdone on the last timeout cycle wins
    drive(1, 0, 0, 32'h0);
    adv();
    for (int c = 1; c < 4; c++) begin
      drive(1, 0, 0, 32'h0);
      chk($sformatf("co c%0d m0_bdone", c), 32'(o_done[0][0]), 32'h0);
      adv();
    end
    drive(1, 0, 1, 32'hCAFE_F00D);
    chk("co m0_bdone", 32'(o_done[0][0]), 32'h1);
    chk("co m0_berr", 32'(o_err[0][0]), 32'h0);
    chk("co m0_rdata", o_rd[0][0], 32'hCAFE_F00D);
    adv();
    drive(0, 0, 0, 32'h0);
    chk("co idle s_bstart", 32'(o_sbs[0]), 32'h0);
    adv();

    // Master 1 aborts after grant; slave transaction still runs, completion suppressed
    do_reset();
    m_addr[1] = 32'h500;
    drive(0, 1, 0, 32'h0);
    adv();
    drive(0, 1, 0, 32'h0);
    chk("ab s_bstart", 32'(o_sbs[0]), 32'h1);
    chk("ab s_addr", o_saddr[0], 32'h500);
    adv();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 32'h0);
      chk($sformatf("ab hold%0d s_bstart", c), 32'(o_sbs[0]), 32'h1);
      chk($sformatf("ab hold%0d m1_bdone", c), 32'(o_done[0][1]), 32'h0);
      adv();
    end
    drive(0, 0, 1, 32'h5A5A_5A5A);
    chk("ab done s_bstart", 32'(o_sbs[0]), 32'h1);
    chk("ab done m1_bdone", 32'(o_done[0][1]), 32'h0);
    chk("ab done m1_rdata", o_rd[0][1], 32'h0);
    adv();
    drive(0, 0, 0, 32'h0);
    chk("ab idle s_bstart", 32'(o_sbs[0]), 32'h0);
    adv();

    // Reset in the middle of a grant, then normal arbitration
    do_reset();
    m_addr[0] = 32'h200;
    drive(1, 0, 0, 32'h0);
    adv();
    rst = 1'b1;
    drive(1, 0, 0, 32'h0);
    chk("mr s_bstart", 32'(o_sbs[0]), 32'h1);
    chk("mr m0_bdone", 32'(o_done[0][0]), 32'h0);
    adv();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0);
    chk("mr after s_bstart", 32'(o_sbs[0]), 32'h0);
    chk("mr after m0_bdone", 32'(o_done[0][0]), 32'h0);
    adv();
    drive(1, 1, 0, 32'h0);
    adv();
    drive(1, 1, 1, 32'h77);
    chk("mr regrant s_addr", o_saddr[0], 32'h200);
    chk("mr regrant m0_bdone", 32'(o_done[0][0]), 32'h1);
    chk("mr regrant m1_bdone", 32'(o_done[0][1]), 32'h0);
    chk("mr regrant m0_rdata", o_rd[0][0], 32'h77);
    adv();

    // Random traffic on both instances against the reference model
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int j = 0; j < 2; j++) begin
        m_bs[j]    = m_bs[j] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        m_tt[j]    = ttype_e'($urandom_range(0, 1));
        m_ts[j]    = tsize_e'($urandom_range(0, 2));
        m_addr[j]  = $urandom;
        m_wdata[j] = $urandom;
      end
      s_bdone = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      @(negedge clk);
      model_cycle(0, 1'b1);
      model_cycle(1, 1'b0);
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
